// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions used by the initiator and the CSR slave.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    WR_REQ  = 3'b001,
    WR_RESP = 3'b010,
    RD_REQ  = 3'b011,
    RD_RESP = 3'b100,
    RSP     = 3'b101
  } mst_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
// Optional response-wait timeout enabled by defining AXIL_MST_TIMEOUT_EN.
module axi4_lite_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  mst_state_t              state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]   awaddr_r, awaddr_s, araddr_r, araddr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s, rsp_rdata_r, rsp_rdata_s;
  logic [DATA_WIDTH/8-1:0] wstrb_r, wstrb_s;
  logic                    awvalid_r, awvalid_s, wvalid_r, wvalid_s;
  logic                    bready_r, bready_s, arvalid_r, arvalid_s;
  logic                    rready_r, rready_s, rsp_valid_r, rsp_valid_s;
  logic [1:0]              rsp_resp_r, rsp_resp_s;
  logic                    rsp_timeout_r, rsp_timeout_s;
  logic                    wr_done_s, timeout_hit_s;

  // Each write channel retires on its own handshake; the pair is done when neither is pending.
  assign wr_done_s = (~awvalid_r | M_AXI_AWREADY) & (~wvalid_r | M_AXI_WREADY);

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt_r;

  // Cycles spent in a response-wait state; zero on every entry.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wait_cnt_r <= {CW{1'b0}};
    end else if (state_r == WR_RESP || state_r == RD_RESP) begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end else begin
      wait_cnt_r <= {CW{1'b0}};
    end
  end

  assign timeout_hit_s = (state_r == WR_RESP || state_r == RD_RESP) && (wait_cnt_r == TO_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (cmd_valid) state_nxt_s = cmd_write ? WR_REQ : RD_REQ;
               else           state_nxt_s = IDLE;
      WR_REQ:  if (wr_done_s) state_nxt_s = WR_RESP;
               else           state_nxt_s = WR_REQ;
      WR_RESP: if (M_AXI_BVALID || timeout_hit_s) state_nxt_s = RSP;
               else                               state_nxt_s = WR_RESP;
      RD_REQ:  if (M_AXI_ARREADY) state_nxt_s = RD_RESP;
               else               state_nxt_s = RD_REQ;
      RD_RESP: if (M_AXI_RVALID || timeout_hit_s) state_nxt_s = RSP;
               else                               state_nxt_s = RD_RESP;
      RSP:     if (rsp_ready) state_nxt_s = IDLE;
               else           state_nxt_s = RSP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless a transition updates it.
  always_comb begin
    awaddr_s      = awaddr_r;
    wdata_s       = wdata_r;
    wstrb_s       = wstrb_r;
    araddr_s      = araddr_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    bready_s      = bready_r;
    arvalid_s     = arvalid_r;
    rready_s      = rready_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_resp_s    = rsp_resp_r;
    rsp_timeout_s = rsp_timeout_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_write) begin
          awaddr_s  = cmd_addr;
          wdata_s   = cmd_wdata;
          wstrb_s   = cmd_wstrb;
          awvalid_s = 1'b1;
          wvalid_s  = 1'b1;
        end else if (cmd_valid) begin
          araddr_s  = cmd_addr;
          arvalid_s = 1'b1;
        end else begin
          awvalid_s = 1'b0;
          arvalid_s = 1'b0;
        end
      end
      WR_REQ: begin
        if (M_AXI_AWREADY) awvalid_s = 1'b0;
        else               awvalid_s = awvalid_r;
        if (M_AXI_WREADY)  wvalid_s  = 1'b0;
        else               wvalid_s  = wvalid_r;
        if (wr_done_s)     bready_s  = 1'b1;
        else               bready_s  = 1'b0;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = M_AXI_BRESP;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_timeout_s = 1'b0;
        end else if (timeout_hit_s) begin
          bready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = SLVERR;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_timeout_s = 1'b1;
        end else begin
          bready_s      = 1'b1;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
        end else begin
          arvalid_s = 1'b1;
        end
      end
      RD_RESP: begin
        if (M_AXI_RVALID) begin
          rready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = M_AXI_RRESP;
          rsp_rdata_s   = M_AXI_RDATA;
          rsp_timeout_s = 1'b0;
        end else if (timeout_hit_s) begin
          rready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_resp_s    = SLVERR;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_timeout_s = 1'b1;
        end else begin
          rready_s      = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) rsp_valid_s = 1'b0;
        else           rsp_valid_s = 1'b1;
      end
      default: begin
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awaddr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r       <= {DATA_WIDTH{1'b0}};
      wstrb_r       <= {(DATA_WIDTH/8){1'b0}};
      araddr_r      <= {ADDR_WIDTH{1'b0}};
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
    end else begin
      awaddr_r      <= awaddr_s;
      wdata_r       <= wdata_s;
      wstrb_r       <= wstrb_s;
      araddr_r      <= araddr_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      arvalid_r     <= arvalid_s;
      rready_r      <= rready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_resp_r    <= rsp_resp_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  assign cmd_ready     = (state_r == IDLE);
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
`ifdef AXIL_MST_TIMEOUT_EN
  assign rsp_timeout   = rsp_timeout_r;
`else
  assign rsp_timeout   = 1'b0;
`endif
  assign M_AXI_AWADDR  = awaddr_r;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = wstrb_r;
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_BREADY  = bready_r;
  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master; the timeout step runs when AXIL_MST_TIMEOUT_EN is defined.
module tb_axi4_lite_master;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  axi4_lite_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h000;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_payload", {awaddr, araddr, wdata, wstrb}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Zero-wait write.
    send(1'b1, 12'h000, 32'h0000_0001, 4'hF);
    tick();  // cycle 1
    cmd_valid = 1'b0;
    chk("w1_aw_w_valid", {awvalid, wvalid}, 2'b11);
    chk("w1_awaddr", awaddr, 12'h000);
    chk("w1_wdata", wdata, 32'h1);
    chk("w1_prot", {awprot, arprot}, 0);
    chk("w1_cmd_ready_busy", cmd_ready, 0);
    awready = 1'b1; wready = 1'b1;
    tick();  // cycle 2
    awready = 1'b0; wready = 1'b0;
    chk("w1_bready", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1'b1; bresp = 2'b00;
    tick();  // cycle 3
    bvalid = 1'b0;
    chk("w1_rsp_valid", {rsp_valid, bready}, 2'b10);
    chk("w1_rsp", {rsp_resp, rsp_rdata, rsp_timeout}, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w1_back_idle", {cmd_ready, rsp_valid}, 2'b10);

    // Read with a stalled AR channel.
    send(1'b0, 12'h010, 32'h0, 4'h0);
    tick();  // cycle 1
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("r2_ar_stall", {arvalid, araddr, rready}, {1'b1, 12'h010, 1'b0});
      tick();
    end
    chk("r2_ar_pre_hs", {arvalid, araddr}, {1'b1, 12'h010});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("r2_rready", {arvalid, rready}, 2'b01);
    tick();
    chk("r2_rready_hold", rready, 1);
    rvalid = 1'b1; rdata = 32'hA5A5_0010; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    chk("r2_rdata", {rsp_valid, rsp_rdata, rsp_resp, rready}, {1'b1, 32'hA5A5_0010, 2'b00, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("r2_back_idle", cmd_ready, 1);

    // Skewed write channels: W at cycle 1, AW at cycle 5.
    send(1'b1, 12'h004, 32'hDEAD_BEEF, 4'h3);
    tick();  // cycle 1
    cmd_valid = 1'b0;
    chk("w3_payload", {awaddr, wdata, wstrb}, {12'h004, 32'hDEAD_BEEF, 4'h3});
    wready = 1'b1;
    tick();  // cycle 2
    wready = 1'b0;
    for (int i = 2; i < 5; i++) begin
      chk("w3_aw_held", {awvalid, wvalid, bready, awaddr}, {3'b100, 12'h004});
      tick();
    end
    chk("w3_aw_c5", {awvalid, wvalid, bready}, 3'b100);
    awready = 1'b1;
    tick();  // cycle 6
    awready = 1'b0;
    chk("w3_bready", {awvalid, bready}, 2'b01);
    bvalid = 1'b1; bresp = 2'b01;
    tick();
    chk("w3_one_b", {bready, rsp_valid, rsp_resp}, {2'b01, 2'b01});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w3_b_ignored_idle", {bready, rsp_valid, cmd_ready}, 3'b001);
    bvalid = 1'b0;

    // DECERR with response back-pressure.
    send(1'b1, 12'h008, 32'h1234_5678, 4'hF);
    tick();
    send(1'b0, 12'h00C, 32'h0, 4'h0);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b11;
    tick();  // cycle 3
    bvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("e4_hold", {rsp_valid, rsp_resp, rsp_rdata, cmd_ready, arvalid}, {1'b1, 2'b11, 32'h0, 2'b00});
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("e4_idle_after", {cmd_ready, rsp_valid}, 2'b10);

    // Reset while waiting in RD_RESP.
    send(1'b0, 12'h020, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("x5_in_rd_resp", rready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("x5_async_clear", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 7'b0000001);
    @(negedge clk); rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    rvalid = 1'b0;
    chk("x5_no_rsp", {rsp_valid, rready, cmd_ready}, 3'b001);

`ifdef AXIL_MST_TIMEOUT_EN
    // Read whose data never arrives.
    send(1'b0, 12'h030, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    arready = 1'b1;
    tick();  // enters RD_RESP
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_rready_wait", {rready, rsp_valid}, 2'b10);
      tick();
    end
    chk("t6_timeout", {rready, rsp_valid, rsp_resp, rsp_timeout, rsp_rdata}, {2'b01, 2'b10, 1'b1, 32'h0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t6_idle", cmd_ready, 1);
`else
    chk("t6_timeout_tied", rsp_timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
